// File: rtl/chebyshev_down_counter_if.sv
// Handshake bundle for chebyshev_down_counter.
//   clear, start, count_from, ready : controller -> sequencer
//   out, valid, first, last         : current beat (index and flags)
//   busy, done                      : sequence status / completion pulse
interface chebyshev_down_counter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  clear;
  logic                  start;
  logic [DATA_WIDTH-1:0] count_from;
  logic                  ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  valid;
  logic                  first;
  logic                  last;
  logic                  busy;
  logic                  done;

  modport master (
    output clear, start, count_from, ready,
    input  out, valid, first, last, busy, done
  );

  modport slave (
    input  clear, start, count_from, ready,
    output out, valid, first, last, busy, done
  );
endinterface

// File: rtl/chebyshev_down_counter.sv
// Reverse-order index sequencer feeding Clenshaw coefficient reads.
// On start, issues count_from, count_from-1, ... COUNT_TO, one index per
// accepted beat (valid && ready), flags first/last beats, pulses done.
// Ports:
//   clock  : sole clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : chebyshev_down_counter_if.slave (controls, beat, status)
//
// state | meaning
// IDLE  | waiting for start; valid low, out holds
// RUN   | issuing beats; valid high, stalls while ready low
// DONE  | single-cycle completion, done high
module chebyshev_down_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_TO   = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  chebyshev_down_counter_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] TERM = DATA_WIDTH'(COUNT_TO);
  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] out_r;
  logic                  valid_r;
  logic                  first_r;
  logic                  last_r;
  logic                  done_r;

  // Borrow out of an extended subtraction flags count_from < COUNT_TO
  // without a compare that degenerates to a constant when COUNT_TO is 0.
  logic [DATA_WIDTH:0]   start_diff;
  logic                  start_empty;
  logic [DATA_WIDTH-1:0] out_dec;
  logic                  transfer;

  assign start_diff  = {1'b0, bus.count_from} - {1'b0, TERM};
  assign start_empty = start_diff[DATA_WIDTH];
  assign out_dec     = out_r - ONE;
  assign transfer    = valid_r && bus.ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      out_r   <= '0;
      valid_r <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (bus.clear) begin
      // abort wins over start and transfer; out keeps its value
      state   <= IDLE;
      valid_r <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            if (start_empty) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state   <= RUN;
              out_r   <= bus.count_from;
              valid_r <= 1'b1;
              first_r <= 1'b1;
              last_r  <= (bus.count_from == TERM);
            end
          end
        end
        RUN: begin
          if (transfer) begin
            first_r <= 1'b0;
            if (last_r) begin
              state   <= DONE;
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              out_r  <= out_dec;
              last_r <= (out_dec == TERM);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_r <= 1'b0;
          first_r <= 1'b0;
          last_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out   = out_r;
  assign bus.valid = valid_r;
  assign bus.first = first_r;
  assign bus.last  = last_r;
  assign bus.done  = done_r;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_chebyshev_down_counter.sv
// Bench for chebyshev_down_counter: two instances (COUNT_TO=0 and 2) share
// one stimulus stream; each is compared every cycle against a queue model
// holding the indices still to be issued.
module tb_chebyshev_down_counter;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic [DW-1:0] count_from = '0;

  always #5 clock = ~clock;

  chebyshev_down_counter_if #(.DATA_WIDTH(DW)) bus0 ();
  chebyshev_down_counter_if #(.DATA_WIDTH(DW)) bus2 ();

  assign bus0.clear = clear;
  assign bus0.start = start;
  assign bus0.count_from = count_from;
  assign bus0.ready = ready;
  assign bus2.clear = clear;
  assign bus2.start = start;
  assign bus2.count_from = count_from;
  assign bus2.ready = ready;

  chebyshev_down_counter #(.DATA_WIDTH(DW), .COUNT_TO(0)) dut0 (
    .clock(clock), .resetn(resetn), .bus(bus0)
  );
  chebyshev_down_counter #(.DATA_WIDTH(DW), .COUNT_TO(2)) dut2 (
    .clock(clock), .resetn(resetn), .bus(bus2)
  );

  int            errors = 0;
  int            checks = 0;
  string         cur_tag = "reset";
  int            kk [2] = '{0, 2};
  int            mq [2][$];
  logic [DW-1:0] m_out [2];
  bit            m_first [2];
  bit            m_done [2];

  task automatic chk(input string name, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d %s: observed %0h expected %0h", cur_tag, d, name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      m_out[d] = '0;
      m_first[d] = 1'b0;
      m_done[d] = 1'b0;
    end
  endtask

  // One rising edge of the reference behaviour, using the inputs seen at it.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (clear) begin
        mq[d].delete();
        m_first[d] = 1'b0;
        m_done[d] = 1'b0;
      end else if (m_done[d]) begin
        m_done[d] = 1'b0;
      end else if (mq[d].size() > 0) begin
        if (ready) begin
          void'(mq[d].pop_front());
          m_first[d] = 1'b0;
          if (mq[d].size() == 0) m_done[d] = 1'b1;
          else m_out[d] = DW'(mq[d][0]);
        end
      end else if (start) begin
        if (int'(count_from) >= kk[d]) begin
          for (int v = int'(count_from); v >= kk[d]; v--) mq[d].push_back(v);
          m_out[d] = count_from;
          m_first[d] = 1'b1;
        end else begin
          m_done[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [DW-1:0] o_out;
      logic o_valid, o_first, o_last, o_busy, o_done;
      bit e_valid;
      if (d == 0) begin
        o_out = bus0.out; o_valid = bus0.valid; o_first = bus0.first;
        o_last = bus0.last; o_busy = bus0.busy; o_done = bus0.done;
      end else begin
        o_out = bus2.out; o_valid = bus2.valid; o_first = bus2.first;
        o_last = bus2.last; o_busy = bus2.busy; o_done = bus2.done;
      end
      e_valid = (mq[d].size() > 0);
      chk("out",   d, 32'(o_out),   32'(m_out[d]));
      chk("valid", d, 32'(o_valid), 32'(e_valid));
      chk("first", d, 32'(o_first), 32'(m_first[d]));
      chk("last",  d, 32'(o_last),  32'(e_valid && mq[d].size() == 1));
      chk("busy",  d, 32'(o_busy),  32'(e_valid || m_done[d]));
      chk("done",  d, 32'(o_done),  32'(m_done[d]));
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (!resetn) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  function automatic bit any_active();
    return (mq[0].size() > 0) || m_done[0] || (mq[1].size() > 0) || m_done[1];
  endfunction

  task automatic run_until_idle(input int max, input bit rnd);
    int n = 0;
    while (any_active() && n < max) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    ready = 1'b1;
    checks++;
    assert (n < max) else begin
      errors++;
      $error("FAIL %s timeout: observed %0d cycles expected below %0d", cur_tag, n, max);
    end
  endtask

  task automatic kick(input logic [DW-1:0] cf);
    count_from = cf;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    model_reset();
    #1;
    check_all();
    step();
    step();
    #3 resetn = 1'b1;
    step();

    cur_tag = "basic";
    kick(8'd5);
    run_until_idle(20, 1'b0);

    cur_tag = "backpressure";
    kick(8'd3);
    for (int i = 0; i < 7; i++) begin
      ready = pat[i];
      step();
    end
    ready = 1'b1;
    run_until_idle(20, 1'b0);

    cur_tag = "single_beat";
    kick(8'd2);
    run_until_idle(20, 1'b0);

    cur_tag = "empty";
    kick(8'd1);
    run_until_idle(20, 1'b0);

    cur_tag = "full_range";
    kick(8'd255);
    run_until_idle(300, 1'b0);

    cur_tag = "ignored_start";
    kick(8'd5);
    step();
    count_from = 8'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!m_done[0] && n < 50) begin
      step();
      n++;
    end
    chk("reach_done", 0, 32'(bus0.done), 32'd1);
    kick(8'd9);
    cur_tag = "restart";
    kick(8'd3);
    chk("restart_out", 0, 32'(bus0.out), 32'd3);
    chk("restart_valid", 0, 32'(bus0.valid), 32'd1);
    run_until_idle(40, 1'b0);

    cur_tag = "abort";
    kick(8'd6);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort_busy", 0, 32'(bus0.busy), 32'd0);
    step();
    run_until_idle(20, 1'b0);

    cur_tag = "clear_start";
    clear = 1'b1;
    kick(8'd4);
    clear = 1'b0;
    step();

    cur_tag = "async_reset";
    kick(8'd7);
    step();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 resetn = 1'b1;
    step();
    kick(8'd4);
    run_until_idle(20, 1'b0);

    cur_tag = "random";
    for (int r = 0; r < 8; r++) begin
      kick(DW'($urandom_range(0, 20)));
      run_until_idle(200, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
